// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequences all writes into the branch predictor BTB.
// Resolved EX outcomes are checked for mispredicts (registered redirect),
// buffered in a small FIFO and drained one per handshake to the BTB
// update port. A flush request runs a full-table invalidate walk.
// Optional: define BP_UPD_PERF_EN to add saturating branch/mispredict counters.
module bp_update_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BTB_ROWS   = 16,
    parameter int QDEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ex_valid,
    output logic                        ex_ready,
    input  logic [DATA_WIDTH-1:0]       ex_pc,
    input  logic [DATA_WIDTH-1:0]       ex_target,
    input  logic                        ex_taken,
    input  logic                        ex_is_jal,
    input  logic                        ex_pred_taken,
    input  logic [DATA_WIDTH-1:0]       ex_pred_target,
    input  logic                        flush_req,
    output logic                        upd_valid,
    input  logic                        upd_ready,
    output logic [$clog2(BTB_ROWS)-1:0] upd_index,
    output logic [DATA_WIDTH-1:0]       upd_pc,
    output logic [DATA_WIDTH-1:0]       upd_target,
    output logic                        upd_taken,
    output logic                        upd_type,
    output logic                        upd_inval,
    output logic                        mispredict,
    output logic [DATA_WIDTH-1:0]       redirect_pc,
`ifdef BP_UPD_PERF_EN
    output logic [31:0]                 perf_branches,
    output logic [31:0]                 perf_mispredicts,
`endif
    output logic                        busy
);
    localparam int IW = $clog2(BTB_ROWS);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0]   QFULL    = (PW+1)'(QDEPTH);
    localparam logic [IW-1:0] ROW_LAST = IW'(BTB_ROWS - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] target;
        logic                  taken;
        logic                  is_jal;
    } outcome_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state;
    outcome_t      fifo [QDEPTH];
    outcome_t      head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, cnt_nxt;
    logic [IW-1:0] walk_idx;
    logic          accept, pop, err;

    // flush always wins over a same-cycle outcome; EX must hold it
    assign ex_ready = (count != QFULL) && (state != FLUSH) && !flush_req;
    assign accept   = ex_valid && ex_ready;
    assign pop      = (state == RUN) && upd_ready;
    assign err      = (ex_pred_taken != ex_taken) ||
                      (ex_taken && (ex_pred_target != ex_target));
    assign head     = fifo[rd_ptr];

    // occupancy after this cycle's enqueue/dequeue
    always_comb begin
        cnt_nxt = count;
        if (accept) cnt_nxt = cnt_nxt + (PW+1)'(1);
        if (pop)    cnt_nxt = cnt_nxt - (PW+1)'(1);
    end

    // update port is driven straight from the state register and FIFO head
    assign upd_valid  = (state != IDLE);
    assign busy       = (state != IDLE);
    assign upd_inval  = (state == FLUSH);
    assign upd_index  = (state == FLUSH) ? walk_idx : head.pc[IW+1:2];
    assign upd_pc     = head.pc;
    assign upd_target = head.target;
    assign upd_taken  = head.taken;
    assign upd_type   = head.is_jal;

    // control FSM and invalidate-walk index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            walk_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req)   state <= FLUSH;
                    else if (accept) state <= RUN;
                end
                RUN: begin
                    if (flush_req)           state <= FLUSH;
                    else if (cnt_nxt == '0)  state <= IDLE;
                end
                FLUSH: begin
                    if (upd_ready) begin
                        if (walk_idx == ROW_LAST) begin
                            walk_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            walk_idx <= walk_idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers/occupancy; a flush from RUN discards the queue and any pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (state == RUN && flush_req) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            count <= cnt_nxt;
        end
    end

    // FIFO storage; contents are meaningful only below count, so no reset
    always_ff @(posedge clk) begin
        if (accept) fifo[wr_ptr] <= '{pc: ex_pc, target: ex_target,
                                      taken: ex_taken, is_jal: ex_is_jal};
    end

    // one-cycle redirect pulse, independent of FIFO state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= accept && err;
            if (accept) redirect_pc <= ex_taken ? ex_target : ex_pc + DATA_WIDTH'(4);
        end
    end

`ifdef BP_UPD_PERF_EN
    // saturating event counters; only reset clears them, never a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (accept && perf_branches != 32'hFFFF_FFFF)
                perf_branches <= perf_branches + 32'd1;
            if (accept && err && perf_mispredicts != 32'hFFFF_FFFF)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: directed + random stimulus against a queue-based
// reference model of the BTB update controller.
module tb_bp_update_ctrl;
    localparam int DW = 32;
    localparam int ROWS = 16;
    localparam int QD = 4;

    logic          clk, rst;
    logic          ex_valid, ex_ready, ex_taken, ex_is_jal, ex_pred_taken;
    logic [DW-1:0] ex_pc, ex_target, ex_pred_target;
    logic          flush_req, upd_valid, upd_ready, upd_taken, upd_type, upd_inval;
    logic [3:0]    upd_index;
    logic [DW-1:0] upd_pc, upd_target, redirect_pc;
    logic          mispredict, busy;
`ifdef BP_UPD_PERF_EN
    logic [31:0]   perf_branches, perf_mispredicts;
`endif

    bp_update_ctrl #(.DATA_WIDTH(DW), .BTB_ROWS(ROWS), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_taken(ex_taken), .ex_is_jal(ex_is_jal),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush_req(flush_req),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_type(upd_type), .upd_inval(upd_inval),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
`ifdef BP_UPD_PERF_EN
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: outcome queue, flush-walk flag, expected pulse
    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] tgt;
        logic          tk;
        logic          jal;
    } ent_t;
    ent_t          q[$];
    bit            flushing;
    int            walk;
    logic          e_misp;
    logic [DW-1:0] e_redir;
    int unsigned   m_branches, m_misp;
    int            passed, failed, total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        flushing = 0;
        walk = 0;
        e_misp = 0;
        e_redir = '0;
        m_branches = 0;
        m_misp = 0;
    endtask

    task automatic chk_reset();
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_inval", upd_inval, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ex_ready", ex_ready, 1);
    endtask

    // check outputs at negedge against the model, then advance the model
    task automatic step();
        logic er, ev, acc, err;
        @(negedge clk);
        ev = flushing || (q.size() > 0);
        er = !flushing && (q.size() < QD) && !flush_req;
        chk("ex_ready", ex_ready, er);
        chk("upd_valid", upd_valid, ev);
        chk("busy", busy, ev);
        chk("mispredict", mispredict, e_misp);
        if (e_misp) chk("redirect_pc", redirect_pc, e_redir);
        if (flushing) begin
            chk("inval_flag", upd_inval, 1);
            chk("inval_index", upd_index, walk);
        end else if (q.size() > 0) begin
            chk("upd_inval", upd_inval, 0);
            chk("upd_index", upd_index, (q[0].pc >> 2) % ROWS);
            chk("upd_pc", upd_pc, q[0].pc);
            chk("upd_target", upd_target, q[0].tgt);
            chk("upd_taken", upd_taken, q[0].tk);
            chk("upd_type", upd_type, q[0].jal);
        end
`ifdef BP_UPD_PERF_EN
        chk("perf_branches", perf_branches, m_branches);
        chk("perf_mispredicts", perf_mispredicts, m_misp);
`endif
        acc = ex_valid && er;
        err = (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target);
        e_misp = acc && err;
        if (acc) e_redir = ex_taken ? ex_target : ex_pc + 32'd4;
        if (acc) m_branches++;
        if (acc && err) m_misp++;
        if (flushing) begin
            if (upd_ready) begin
                walk++;
                if (walk == ROWS) begin
                    walk = 0;
                    flushing = 0;
                end
            end
        end else if (flush_req) begin
            q.delete();
            flushing = 1;
            walk = 0;
        end else begin
            if (q.size() > 0 && upd_ready) void'(q.pop_front());
            if (acc) q.push_back('{ex_pc, ex_target, ex_taken, ex_is_jal});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] tgt,
                          input logic tk, input logic jal, input logic pt,
                          input logic [DW-1:0] ptgt);
        ex_valid = v; ex_pc = pc; ex_target = tgt; ex_taken = tk;
        ex_is_jal = jal; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    initial begin
        passed = 0; failed = 0; total = 0;
        model_reset();
        rst = 1'b0;
        flush_req = 0; upd_ready = 0;
        set_ex(0, '0, '0, 0, 0, 0, '0);
        #3 chk_reset();
        @(posedge clk); #1 rst = 1'b1;
        step();

        // single correctly predicted taken branch, drains then IDLE
        upd_ready = 1;
        set_ex(1, 32'h100, 32'h140, 1, 0, 1, 32'h140);
        step();
        ex_valid = 0;
        repeat (3) step();

        // not-taken mispredict then wrong-target mispredict
        set_ex(1, 32'h208, 32'h300, 0, 0, 1, 32'h300);
        step();
        ex_valid = 0;
        step();
        set_ex(1, 32'h20C, 32'h400, 1, 0, 1, 32'h300);
        step();
        ex_valid = 0;
        repeat (3) step();

        // fill the FIFO with the port stalled; 5th is held off
        upd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 16), i[0], i[1], 0, '0);
            step();
        end
        set_ex(1, 32'h1010, 32'h3000, 1, 1, 1, 32'h3000);
        repeat (3) step();
        upd_ready = 1;
        step();
        ex_valid = 0;
        repeat (7) step();

        // flush from RUN with 3 queued entries, each invalidate stalled once
        upd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 32'h500 + 32'(i * 4), 32'h600, 1, 0, 1, 32'h600);
            step();
        end
        ex_valid = 0;
        flush_req = 1;
        step();
        flush_req = 0;
        for (int i = 0; i < 80 && flushing; i++) begin
            upd_ready = i[0];
            step();
        end
        upd_ready = 1;
        step();
        chk("flush_done_busy", busy, 0);

        // ex_valid with flush_req: flush wins; then reset mid-walk
        set_ex(1, 32'h700, 32'h800, 0, 0, 1, 32'h800);
        flush_req = 1;
        step();
        flush_req = 0;
        ex_valid = 0;
        repeat (5) step();
        #2 rst = 1'b0;
        #1 chk_reset();
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic tk, jal;
            logic [DW-1:0] tgt;
            jal = ($urandom_range(0, 3) == 0);
            tk  = jal | 1'($urandom_range(0, 1));
            tgt = $urandom & ~32'h3;
            set_ex(1'($urandom_range(0, 1)), $urandom & ~32'h3, tgt, tk, jal,
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) != 0) ? tgt : ($urandom & ~32'h3));
            flush_req = ($urandom_range(0, 49) == 0);
            upd_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        ex_valid = 0;
        flush_req = 0;
        upd_ready = 1;
        for (int i = 0; i < 40 && (flushing || q.size() > 0); i++) step();
        step();
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
